// File: rtl/fsb_refresh_timer_if.sv
// fsb_refresh_timer_if: bus-side signals between the refresh timer and the arbiter/cycle controller.
interface fsb_refresh_timer_if #(
    parameter int DEBT_MAX  = 4,
    parameter int TO_STAGES = 2
);
    localparam int PW = $clog2(DEBT_MAX + 1);
    logic                 CACT;
    logic                 RefAck;
    logic                 RefReq;
    logic                 RefUrgent;
    logic [PW-1:0]        RefPending;
    logic                 RefOverflow;
    logic [TO_STAGES-1:0] Timeout;
    modport master (
        output CACT, RefAck,
        input  RefReq, RefUrgent, RefPending, RefOverflow, Timeout
    );
    modport slave (
        input  CACT, RefAck,
        output RefReq, RefUrgent, RefPending, RefOverflow, Timeout
    );
endinterface

// File: rtl/fsb_refresh_timer.sv
// fsb_refresh_timer: refresh interval counter with saturating debt, plus a prescaled bus-cycle timeout chain.
module fsb_refresh_timer #(
    parameter int REF_PERIOD = 288,
    parameter int URGENT_AT  = 256,
    parameter int DEBT_MAX   = 4,
    parameter int TICK_DIV   = 64,
    parameter int TO_STAGES  = 2
) (
    input logic                FCLK,
    input logic                nRESET,
    fsb_refresh_timer_if.slave bus
);
    localparam int RW = $clog2(REF_PERIOD);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(DEBT_MAX + 1);
    localparam logic [RW-1:0] REF_LAST   = RW'(REF_PERIOD - 1);
    localparam logic [RW-1:0] URGENT_CNT = RW'(URGENT_AT);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] DEBT_TOP   = PW'(DEBT_MAX);
    localparam logic [PW-1:0] DEBT_ONE   = PW'(1);

    logic [RW-1:0]        ref_cnt_q, ref_cnt_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [PW-1:0]        debt_q, debt_d;
    logic                 ovf_q, ovf_d;
    logic [TO_STAGES-1:0] to_q, to_d;
    logic                 wrap, tick, ack;

    // An ack against zero debt is dropped so the debt never underflows.
    always_comb begin
        wrap       = ref_cnt_q == REF_LAST;
        tick       = tick_cnt_q == TICK_LAST;
        ack        = bus.RefAck && debt_q != '0;
        ref_cnt_d  = wrap ? '0 : ref_cnt_q + RW'(1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        debt_d     = (wrap && !ack && debt_q != DEBT_TOP) ? debt_q + DEBT_ONE
                   : (!wrap && ack) ? debt_q - DEBT_ONE : debt_q;
        ovf_d      = ovf_q || (wrap && !ack && debt_q == DEBT_TOP);
        to_d       = !bus.CACT ? '0 : tick ? ((to_q << 1) | TO_STAGES'(1)) : to_q;
    end

    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            ref_cnt_q  <= '0;
            tick_cnt_q <= '0;
            debt_q     <= DEBT_ONE;
            ovf_q      <= 1'b0;
            to_q       <= '0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            debt_q     <= debt_d;
            ovf_q      <= ovf_d;
            to_q       <= to_d;
        end
    end

    // Outputs decode registered state only; inputs reach them one cycle later.
    assign bus.RefReq      = debt_q != '0;
    assign bus.RefUrgent   = (debt_q > DEBT_ONE) || (debt_q == DEBT_ONE && ref_cnt_q >= URGENT_CNT);
    assign bus.RefPending  = debt_q;
    assign bus.RefOverflow = ovf_q;
    assign bus.Timeout     = to_q;
endmodule

// File: tb/tb_fsb_refresh_timer.sv
// tb_fsb_refresh_timer: directed vector table, corner sequences and randomized run against a cycle-count model.
module tb_fsb_refresh_timer;
    localparam int RP = 288, UA = 256, DM = 4, TD = 64, TS = 2;

    logic FCLK = 1'b0, nRESET = 1'b0, cact = 1'b0, ack = 1'b0;
    always #5 FCLK = ~FCLK;

    fsb_refresh_timer_if #(.DEBT_MAX(DM), .TO_STAGES(TS)) bus ();
    assign bus.CACT   = cact;
    assign bus.RefAck = ack;

    fsb_refresh_timer #(.REF_PERIOD(RP), .URGENT_AT(UA), .DEBT_MAX(DM), .TICK_DIV(TD), .TO_STAGES(TS))
        dut (.FCLK(FCLK), .nRESET(nRESET), .bus(bus.slave));

    typedef struct {
        int at; bit rst; bit ack; bit cact;
        int req; int urg; int pend; int ovf; int to;
    } vec_t;
    vec_t tbl[$];

    int checks = 0, errors = 0, cyc = 0;
    int m_n, m_debt, m_ovf, m_ticks;

    function automatic vec_t v(int at, bit rst, bit a, bit c, int req, int urg, int pend, int ovf, int to);
        vec_t r;
        r.at = at; r.rst = rst; r.ack = a; r.cact = c;
        r.req = req; r.urg = urg; r.pend = pend; r.ovf = ovf; r.to = to;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_all(int req, int urg, int pend, int ovf, int to);
        chk("RefReq", 32'(bus.RefReq), req);
        chk("RefUrgent", 32'(bus.RefUrgent), urg);
        chk("RefPending", 32'(bus.RefPending), pend);
        chk("RefOverflow", 32'(bus.RefOverflow), ovf);
        chk("Timeout", 32'(bus.Timeout), to);
    endtask

    // Reference: debt as a plain integer, timeout as number of ticks seen since CACT rose.
    task automatic m_reset();
        m_n = 0; m_debt = 1; m_ovf = 0; m_ticks = 0;
    endtask

    task automatic m_edge();
        bit wrap, a;
        wrap = (m_n % RP) == RP - 1;
        a = ack && m_debt > 0;
        if (wrap && !a) begin
            if (m_debt == DM) m_ovf = 1;
            else m_debt++;
        end else if (!wrap && a) m_debt--;
        if (!cact) m_ticks = 0;
        else if ((m_n % TD) == TD - 1 && m_ticks < TS) m_ticks++;
        m_n++;
    endtask

    task automatic m_check();
        chk_all(m_debt != 0, m_debt >= 2 || (m_debt == 1 && (m_n % RP) >= UA), m_debt, m_ovf, (1 << m_ticks) - 1);
    endtask

    task automatic do_reset();
        @(negedge FCLK);
        nRESET = 1'b0; ack = 1'b0;
        @(negedge FCLK);
        nRESET = 1'b1;
        m_reset();
        cyc = 0;
    endtask

    task automatic step();
        @(posedge FCLK);
        m_edge();
        #1;
        ack = 1'b0;
        cyc++;
    endtask

    task automatic goto(int c);
        while (cyc < c) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl.push_back(v(0,    1, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(255,  0, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(256,  0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(287,  0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(288,  0, 0, 0, 1, 1, 2, 0, 0));
        tbl.push_back(v(576,  0, 0, 0, 1, 1, 3, 0, 0));
        tbl.push_back(v(863,  0, 0, 0, 1, 1, 3, 0, 0));
        tbl.push_back(v(864,  0, 0, 0, 1, 1, 4, 0, 0));
        tbl.push_back(v(1151, 0, 0, 0, 1, 1, 4, 0, 0));
        tbl.push_back(v(1152, 0, 1, 0, 1, 1, 4, 1, 0));
        tbl.push_back(v(1153, 0, 1, 0, 1, 1, 3, 1, 0));
        tbl.push_back(v(1154, 0, 1, 0, 1, 1, 2, 1, 0));
        tbl.push_back(v(1155, 0, 1, 0, 1, 0, 1, 1, 0));
        tbl.push_back(v(1156, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1157, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0,    1, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(v(10,   0, 1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(v(11,   0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(63,   0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(64,   0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(100,  0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(101,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(120,  0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(127,  0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(128,  0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(191,  0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(192,  0, 0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(v(287,  0, 0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(v(288,  0, 0, 1, 1, 0, 1, 0, 3));
        tbl.push_back(v(543,  0, 0, 1, 1, 0, 1, 0, 3));
        tbl.push_back(v(544,  0, 0, 1, 1, 1, 1, 0, 3));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            goto(tbl[i].at);
            chk_all(tbl[i].req, tbl[i].urg, tbl[i].pend, tbl[i].ovf, tbl[i].to);
            ack  = tbl[i].ack;
            cact = tbl[i].cact;
        end

        // Ack on a wrap edge cancels the increment; ack with zero debt is ignored.
        cact = 1'b0;
        do_reset();
        goto(575);
        chk_all(1, 1, 2, 0, 0);
        ack = 1'b1; step();
        chk_all(1, 1, 2, 0, 0);
        ack = 1'b1; step();
        ack = 1'b1; step();
        chk_all(0, 0, 0, 0, 0);
        ack = 1'b1; step();
        chk_all(0, 0, 0, 0, 0);

        // Asynchronous reset between clock edges while debt and timeouts are built up.
        do_reset();
        cact = 1'b1;
        goto(600);
        chk_all(1, 1, 3, 0, 3);
        #2 nRESET = 1'b0;
        #1 chk_all(1, 0, 1, 0, 0);
        do_reset();

        begin
            int rate;
            rate = 2;
            m_check();
            for (int i = 0; i < 4000; i++) begin
                if (i % 700 == 0) rate = $urandom_range(0, 4);
                ack = $urandom_range(0, 99) < rate;
                if ($urandom_range(0, 149) == 0) cact = ~cact;
                if (i == 2500) begin
                    #2 nRESET = 1'b0;
                    m_reset();
                    #1 m_check();
                    @(negedge FCLK) nRESET = 1'b1;
                    cyc = 0;
                end
                step();
                m_check();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
